// File: rtl/apb4_master_arbiter.sv
// apb4_master_arbiter: round-robin arbiter that lets NUM_REQ requesters
// share a single APB4 master port through an IDLE/SETUP/ACCESS FSM.
// Optional macro APB4_ARB_TIMEOUT_EN: abort ACCESS with rsp_err after
// TIMEOUT_CYCLES wait cycles (undefined: ACCESS waits indefinitely).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/ready        per-requester command handshake
//   req_write/addr/wdata   per-requester command, packed by requester
//   rsp_valid              one-cycle completion pulse to the owner
//   rsp_rdata, rsp_err     shared response data/error, valid with rsp_valid
//   psel..pslverr          APB4 master side
module apb4_master_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 3,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             rsp_err,
   output logic                             psel,
   output logic                             penable,
   output logic                             pwrite,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic [DATA_WIDTH-1:0]            pwdata,
   input  logic [DATA_WIDTH-1:0]            prdata,
   input  logic                             pready,
   input  logic                             pslverr
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IW-1:0]         r_last_grant;
   logic [IW-1:0]         w_last_nxt;
   logic [IW-1:0]         r_owner;
   logic [IW-1:0]         w_owner_nxt;
   logic                  r_psel;
   logic                  w_psel_nxt;
   logic                  r_penable;
   logic                  w_penable_nxt;
   logic                  r_pwrite;
   logic                  w_pwrite_nxt;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [ADDR_WIDTH-1:0] w_paddr_nxt;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic [DATA_WIDTH-1:0] w_pwdata_nxt;
   logic [NUM_REQ-1:0]    r_rsp_valid;
   logic [NUM_REQ-1:0]    w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
   logic                  r_rsp_err;
   logic                  w_rsp_err_nxt;
   logic [NUM_REQ-1:0]    w_ready;

   logic                  w_any_hi;
   logic                  w_any_lo;
   logic [IW-1:0]         w_win_hi;
   logic [IW-1:0]         w_win_lo;
   logic                  w_any;
   logic [IW-1:0]         w_win;
   logic                  w_sel_write;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic                  w_timeout;

   // Round-robin: the lowest valid index above last_grant wins; if none,
   // wrap around to the lowest valid index at or below last_grant.
   always_comb begin
      w_any_hi = 1'b0;
      w_any_lo = 1'b0;
      w_win_hi = '0;
      w_win_lo = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (IW'(i) > r_last_grant) begin
               w_any_hi = 1'b1;
               w_win_hi = IW'(i);
            end else begin
               w_any_lo = 1'b1;
               w_win_lo = IW'(i);
            end
         end
      end
   end

   assign w_any = w_any_hi | w_any_lo;
   assign w_win = w_any_hi ? w_win_hi : w_win_lo;

   always_comb begin
      w_sel_write = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IW'(i) == w_win) begin
            w_sel_write = req_write[i];
            w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef APB4_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_tcnt;

   // Counts ACCESS cycles with pready low; fires on the last allowed one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tcnt <= '0;
      end else if (r_state == S_ACCESS && !pready) begin
         r_tcnt <= r_tcnt + 1'b1;
      end else begin
         r_tcnt <= '0;
      end
   end

   assign w_timeout = (r_state == S_ACCESS) && !pready &&
                      (r_tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] w_unused_to;

   assign w_unused_to = 32'(TIMEOUT_CYCLES);
   assign w_timeout   = 1'b0;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_last_nxt      = r_last_grant;
      w_owner_nxt     = r_owner;
      w_psel_nxt      = r_psel;
      w_penable_nxt   = r_penable;
      w_pwrite_nxt    = r_pwrite;
      w_paddr_nxt     = r_paddr;
      w_pwdata_nxt    = r_pwdata;
      w_rsp_valid_nxt = '0;
      w_rsp_rdata_nxt = '0;
      w_rsp_err_nxt   = 1'b0;
      w_ready         = '0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_ready       = NUM_REQ'(1) << w_win;
               w_owner_nxt   = w_win;
               w_last_nxt    = w_win;
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b0;
               w_pwrite_nxt  = w_sel_write;
               w_paddr_nxt   = w_sel_addr;
               w_pwdata_nxt  = w_sel_write ? w_sel_wdata : '0;
               w_state_nxt   = S_SETUP;
            end
         end
         S_SETUP: begin
            w_penable_nxt = 1'b1;
            w_state_nxt   = S_ACCESS;
         end
         S_ACCESS: begin
            if (pready || w_timeout) begin
               w_psel_nxt      = 1'b0;
               w_penable_nxt   = 1'b0;
               w_rsp_valid_nxt = NUM_REQ'(1) << r_owner;
               w_state_nxt     = S_IDLE;
               if (pready) begin
                  w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
                  w_rsp_err_nxt   = pslverr;
               end else begin
                  w_rsp_err_nxt   = 1'b1;
               end
            end
         end
         default: begin
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= IW'(NUM_REQ - 1);
         r_owner      <= '0;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_pwrite     <= 1'b0;
         r_paddr      <= '0;
         r_pwdata     <= '0;
         r_rsp_valid  <= '0;
         r_rsp_rdata  <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_nxt;
         r_owner      <= w_owner_nxt;
         r_psel       <= w_psel_nxt;
         r_penable    <= w_penable_nxt;
         r_pwrite     <= w_pwrite_nxt;
         r_paddr      <= w_paddr_nxt;
         r_pwdata     <= w_pwdata_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_rdata  <= w_rsp_rdata_nxt;
         r_rsp_err    <= w_rsp_err_nxt;
      end
   end

   assign req_ready = w_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// tb_apb4_master_arbiter: directed bench for apb4_master_arbiter with
// two requesters; inputs driven on falling edges, outputs sampled 1ns later.
module tb_apb4_master_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_write;
   logic [5:0]  req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [2:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int n_tests = 0;
   int n_fail  = 0;

   apb4_master_arbiter #(
      .NUM_REQ        (2),
      .ADDR_WIDTH     (3),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1);
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = 2'b00;
      pready = 1'b0;
      pslverr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_tests++;
      if ({psel, penable, pwrite} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_ctrl got %b want 000",
                  {psel, penable, pwrite});
      end
      n_tests++;
      if ({paddr, pwdata} !== 35'd0) begin
         n_fail++;
         $display("FAIL rst_bus got %h/%h want 0/0", paddr, pwdata);
      end
      n_tests++;
      if ({rsp_valid, rsp_rdata, rsp_err} !== 35'd0) begin
         n_fail++;
         $display("FAIL rst_rsp got %b/%h/%b want 0",
                  rsp_valid, rsp_rdata, rsp_err);
      end
      n_tests++;
      if (req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_ready got %b want 00", req_ready);
      end
   endtask

   task automatic test_idle();
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      n_tests++;
      if (req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_ready got %b want 00", req_ready);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (psel !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_psel got %b want 0", psel);
      end
   endtask

   task automatic test_single_write();
      @(negedge clk);
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr[2:0] = 3'd0;
      req_wdata[31:0] = 32'hDEADBEEF;
      prdata = 32'h11111111;
      pready = 1'b1;
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL wr_ready got %b want 01", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      n_tests++;
      if ({psel, penable, pwrite} !== 3'b101 ||
          paddr !== 3'd0 || pwdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_setup got %b %h %h want 101 0 deadbeef",
                  {psel, penable, pwrite}, paddr, pwdata);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if ({psel, penable} !== 2'b11 || rsp_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL wr_access got %b/%b want 11/00",
                  {psel, penable}, rsp_valid);
      end
      @(negedge clk);
      pready = 1'b0;
      #1;
      n_tests++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 ||
          rsp_rdata !== 32'd0 || psel !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_rsp got %b %b %h %b want 01 0 0 0",
                  rsp_valid, rsp_err, rsp_rdata, psel);
      end
   endtask

   task automatic test_readback();
      int bad = 0;
      @(negedge clk);
      req_valid = 2'b10;
      req_write = 2'b00;
      req_addr = 6'd0;
      req_wdata[63:32] = 32'hFFFFFFFF;
      #1;
      n_tests++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL rd_ready got %b want 10", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      n_tests++;
      if ({psel, penable, pwrite} !== 3'b100 ||
          paddr !== 3'd0 || pwdata !== 32'd0) begin
         n_fail++;
         $display("FAIL rd_setup got %b %h %h want 100 0 0",
                  {psel, penable, pwrite}, paddr, pwdata);
      end
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         #1;
         if (penable !== 1'b1 || paddr !== 3'd0 ||
             rsp_valid !== 2'b00)
            bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rd_wait got %0d bad cycles want 0", bad);
      end
      @(negedge clk);
      pready = 1'b1;
      prdata = 32'hDEADBEEF;
      #1;
      n_tests++;
      if (penable !== 1'b1 || paddr !== 3'd0) begin
         n_fail++;
         $display("FAIL rd_last got %b %h want 1 0", penable, paddr);
      end
      @(negedge clk);
      pready = 1'b0;
      prdata = 32'd0;
      #1;
      n_tests++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hDEADBEEF ||
          rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_rsp got %b %h %b want 10 deadbeef 0",
                  rsp_valid, rsp_rdata, rsp_err);
      end
   endtask

   task automatic test_slave_error();
      @(negedge clk);
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr[2:0] = 3'd4;
      req_wdata[31:0] = 32'hCAFEF00D;
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL err_ready got %b want 01", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      pready = 1'b1;
      pslverr = 1'b1;
      #1;
      n_tests++;
      if (paddr !== 3'd4 || pwdata !== 32'hCAFEF00D ||
          pwrite !== 1'b1) begin
         n_fail++;
         $display("FAIL err_setup got %h %h %b want 4 cafef00d 1",
                  paddr, pwdata, pwrite);
      end
      @(negedge clk);
      @(negedge clk);
      pready = 1'b0;
      pslverr = 1'b0;
      req_valid = 2'b10;
      req_write = 2'b00;
      req_addr[5:3] = 3'd2;
      #1;
      n_tests++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_rsp got %b %b want 01 1",
                  rsp_valid, rsp_err);
      end
      n_tests++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_ready got %b want 10", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      n_tests++;
      if ({psel, penable, pwrite} !== 3'b100 || paddr !== 3'd2 ||
          rsp_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_setup got %b %h %b want 100 2 00",
                  {psel, penable, pwrite}, paddr, rsp_valid);
      end
      @(negedge clk);
      pready = 1'b1;
      prdata = 32'h12345678;
      @(negedge clk);
      pready = 1'b0;
      #1;
      n_tests++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h12345678 ||
          rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_rsp got %b %h %b want 10 12345678 0",
                  rsp_valid, rsp_rdata, rsp_err);
      end
   endtask

   task automatic test_contention();
      int exp;
      int prev = 0;
      int cnt[2];
      logic [1:0] want;
      logic [31:0] wd;
      cnt[0] = 0;
      cnt[1] = 0;
      apply_reset();
      req_valid = 2'b11;
      req_write = 2'b11;
      req_addr = {3'd1, 3'd0};
      req_wdata = {32'hA0000001, 32'hA0000000};
      for (int n = 0; n < 8; n++) begin
         exp = n % 2;
         want = 2'(1 << exp);
         #1;
         n_tests++;
         if (req_ready !== want) begin
            n_fail++;
            $display("FAIL rr_grant%0d got %b want %b",
                     n, req_ready, want);
         end
         if (n > 0) begin
            n_tests++;
            if (rsp_valid !== 2'(1 << prev)) begin
               n_fail++;
               $display("FAIL rr_rsp%0d got %b want %b",
                        n, rsp_valid, 2'(1 << prev));
            end
         end
         cnt[exp]++;
         @(negedge clk);
         if (cnt[exp] == 4)
            req_valid[exp] = 1'b0;
         pready = 1'b1;
         wd = 32'hA0000000 | 32'(exp);
         #1;
         n_tests++;
         if (paddr !== 3'(exp) || pwdata !== wd || psel !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_setup%0d got %h %h want %h %h",
                     n, paddr, pwdata, 3'(exp), wd);
         end
         @(negedge clk);
         @(negedge clk);
         pready = 1'b0;
         prev = exp;
      end
      #1;
      n_tests++;
      if (rsp_valid !== 2'b10 || req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL rr_end got %b/%b want 10/00",
                  rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset_access();
      @(negedge clk);
      req_valid = 2'b01;
      req_write = 2'b00;
      req_addr[2:0] = 3'd3;
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL ra_ready got %b want 01", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      #1;
      n_tests++;
      if ({psel, penable} !== 2'b11) begin
         n_fail++;
         $display("FAIL ra_access got %b want 11", {psel, penable});
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b11;
      #1;
      n_tests++;
      if ({psel, penable} !== 2'b00 || rsp_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL ra_abort got %b/%b want 00/00",
                  {psel, penable}, rsp_valid);
      end
      n_tests++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL ra_regrant got %b want 01", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      n_tests++;
      if (rsp_valid !== 2'b00 || {psel, penable} !== 2'b10) begin
         n_fail++;
         $display("FAIL ra_norsp got %b/%b want 00/10",
                  rsp_valid, {psel, penable});
      end
      @(negedge clk);
      pready = 1'b1;
      @(negedge clk);
      pready = 1'b0;
      #1;
      n_tests++;
      if (rsp_valid !== 2'b01) begin
         n_fail++;
         $display("FAIL ra_rsp got %b want 01", rsp_valid);
      end
   endtask

   task automatic test_timeout();
      int bad = 0;
      @(negedge clk);
      req_valid = 2'b10;
      req_write = 2'b00;
      req_addr[5:3] = 3'd5;
      prdata = 32'h5555AAAA;
      pready = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL to_ready got %b want 10", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
`ifdef APB4_ARB_TIMEOUT_EN
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         #1;
         if ({psel, penable} !== 2'b11 || rsp_valid !== 2'b00)
            bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL to_wait got %0d bad cycles want 0", bad);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 ||
          rsp_rdata !== 32'd0 || {psel, penable} !== 2'b00) begin
         n_fail++;
         $display("FAIL to_rsp got %b %b %h %b want 10 1 0 00",
                  rsp_valid, rsp_err, rsp_rdata, {psel, penable});
      end
`else
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (rsp_valid !== 2'b00)
            bad++;
      end
      n_tests++;
      if (bad != 0 || {psel, penable} !== 2'b11) begin
         n_fail++;
         $display("FAIL to_hold got %0d rsp %b bus want 0 11",
                  bad, {psel, penable});
      end
      apply_reset();
`endif
   endtask

   initial begin
      req_valid = 2'b00;
      req_write = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      test_reset();
      test_idle();
      test_single_write();
      test_readback();
      test_slave_error();
      test_contention();
      test_reset_access();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb4_master_arbiter.md
APB4_MASTER_ARBITER -- requirements
Module: apb4_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one APB4 master port (range 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase wait cycles (used only under APB4_ARB_TIMEOUT_EN).
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester command valid.
REQ-008 SHALL have port req_ready  out  NUM_REQ  per-requester command accepted (one-hot or zero).
REQ-009 SHALL have port req_write  in  NUM_REQ  1=write, 0=read.
REQ-010 SHALL have port req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-011 SHALL have port req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
REQ-012 SHALL have port rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-013 SHALL have port rsp_rdata  out  DATA_WIDTH  read data, shared, valid with rsp_valid.
REQ-014 SHALL have port rsp_err  out  1  error flag, valid with rsp_valid.
REQ-015 SHALL have ports psel, penable, pwrite  out  1 each; paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH; prdata  in  DATA_WIDTH; pready, pslverr  in  1 each: APB4 master side.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; no other states.
REQ-017 IDLE: if any req_valid, SHALL pick winner by round-robin starting at (last_grant+1) mod NUM_REQ, assert req_ready[winner] combinationally that cycle, latch write/addr/wdata, set last_grant=winner, go SETUP.
REQ-018 IDLE with no req_valid: req_ready=0, stay IDLE, last_grant unchanged.
REQ-019 SETUP: psel=1, penable=0, paddr/pwrite/pwdata from latch; next cycle ACCESS unconditionally.
REQ-020 ACCESS: psel=1, penable=1; stay while pready=0; on pready=1 capture prdata (reads) and pslverr, go IDLE.
REQ-021 Cycle after pready sampled high SHALL assert rsp_valid[owner] for exactly one cycle with rsp_rdata=captured prdata (0 for writes), rsp_err=captured pslverr.
REQ-022 Minimum latency: accept at T, SETUP T+1, ACCESS T+2, rsp_valid T+3; new command may be accepted at T+3 (back-to-back, one idle-bus cycle).
REQ-023 paddr, pwrite, pwdata SHALL be stable from SETUP through final ACCESS cycle; pwdata=0 for reads; all APB outputs registered.
REQ-024 Simultaneous requests: only winner sees req_ready; losers keep req_valid and win in later rounds; no requester starved longer than NUM_REQ-1 transfers.
REQ-025 req_valid deasserting while not granted SHALL be ignored (no side effect).

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, last_grant=NUM_REQ-1 (requester 0 highest first priority).
REQ-027 Reset mid-transfer SHALL abort silently: no rsp_valid for the aborted command, bus idle next cycle.

Configuration
REQ-028 Macro APB4_ARB_TIMEOUT_EN defined: counter runs in ACCESS; if pready stays 0 for TIMEOUT_CYCLES cycles, SHALL drop psel/penable, go IDLE, pulse rsp_valid[owner] with rsp_err=1, rsp_rdata=0.
REQ-029 Macro undefined: no counter, ACCESS waits indefinitely, TIMEOUT_CYCLES ignored.

Verification
REQ-030 Single write: req 0 write addr=0 data=0xDEADBEEF, pready=1 immediately -> psel T+1, penable T+2, rsp_valid[0] T+3, rsp_err=0.
REQ-031 Readback: req 1 read addr=0, prdata=0xDEADBEEF with pready after 3 wait states -> rsp_valid[1] one cycle after pready, rsp_rdata=0xDEADBEEF, paddr stable throughout.
REQ-032 Contention: req 0 and 1 both valid from reset, 4 transfers each -> grant order 0,1,0,1,...; each rsp_valid to correct owner.
REQ-033 Slave error: pslverr=1 with pready on write addr=4 -> rsp_err=1, rsp_valid pulse, next command accepted normally.
REQ-034 Reset in ACCESS with pready=0 -> psel=penable=0 next cycle, no rsp_valid, next grant goes to requester 0.
REQ-035 With APB4_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready held 0 -> rsp_valid with rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles; without macro bus still in ACCESS after 100 cycles.
